rs_stream_encoder: RTL

- Parametrised systematic Reed-Solomon encoder over GF(2^EGF_DIM).
- Accepts ENC_SYM message symbols per beat through a valid/ready stream.
- Forwards each message beat unchanged, then appends RSC_PAR_LEN parity symbols as RSC_PAR_LEN/ENC_SYM extra beats.
- Message length is selectable per frame (shortened codes), and a per-frame bypass mode passes data through without parity. Sits between the message generator and the channel interface.

---
 rtl/rs_stream_if.sv | 26 ++
 rtl/rs_stream_encoder.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/rs_stream_if.sv
// Valid/ready stream bundle for the Reed-Solomon stream encoder: message beats
// in, codeword beats out.
interface rs_stream_if #(
    parameter int W = 32
);
    // A beat transfers on a rising clk edge where valid && ready. Once valid is
    // raised, the source holds data (and last/parity) stable until it transfers.
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
    logic         out_last;
    logic         out_parity;

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_last, out_parity
    );

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_last, out_parity
    );
endinterface

// File: rtl/rs_stream_encoder.sv
// Systematic Reed-Solomon encoder that forwards message beats and then appends
// the parity beats, with a per-frame shortened length and a per-frame bypass.
module rs_stream_encoder #(
    parameter int               EGF_DIM       = 8,
    parameter logic [EGF_DIM:0] EGF_PRIM      = 9'h11D,
    parameter int               ENC_SYM       = 4,
    parameter int               RSC_PAR_LEN   = 16,
    parameter int               RSC_FCR       = 0,
    parameter int               MAX_MSG_BEATS = 59
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [$clog2(MAX_MSG_BEATS+1)-1:0] cfg_msg_beats,
    input  logic                             cfg_bypass,
    rs_stream_if.slave                       strm,
    output logic [1:0]                       dbg_state
);
    localparam int SW  = ENC_SYM * EGF_DIM;
    localparam int PW  = RSC_PAR_LEN * EGF_DIM;
    localparam int PB  = RSC_PAR_LEN / ENC_SYM;
    localparam int CW  = $clog2(MAX_MSG_BEATS + 1);
    localparam int PCW = (PB > 1) ? $clog2(PB) : 1;

    function automatic logic [EGF_DIM-1:0] gf_mul(input logic [EGF_DIM-1:0] a,
                                                  input logic [EGF_DIM-1:0] b);
        logic [EGF_DIM-1:0] r;
        logic [EGF_DIM-1:0] x;
        r = '0;
        x = a;
        for (int i = 0; i < EGF_DIM; i++) begin
            if (b[i]) r = r ^ x;
            x = x[EGF_DIM-1] ? ((x << 1) ^ EGF_PRIM[EGF_DIM-1:0]) : (x << 1);
        end
        return r;
    endfunction

    // Expands prod(x + alpha^(FCR+i)); the monic top coefficient is implicit.
    function automatic logic [PW-1:0] gen_poly();
        logic [EGF_DIM-1:0] g [RSC_PAR_LEN+1];
        logic [EGF_DIM-1:0] root;
        logic [PW-1:0]      flat;
        for (int j = 0; j <= RSC_PAR_LEN; j++) g[j] = '0;
        g[0] = EGF_DIM'(1);
        root = EGF_DIM'(1);
        for (int i = 0; i < RSC_FCR; i++) root = gf_mul(root, EGF_DIM'(2));
        for (int i = 0; i < RSC_PAR_LEN; i++) begin
            for (int j = i + 1; j > 0; j--) g[j] = g[j-1] ^ gf_mul(root, g[j]);
            g[0] = gf_mul(root, g[0]);
            root = gf_mul(root, EGF_DIM'(2));
        end
        for (int j = 0; j < RSC_PAR_LEN; j++) flat[j*EGF_DIM +: EGF_DIM] = g[j];
        return flat;
    endfunction

    localparam logic [PW-1:0] GEN = gen_poly();

    // One beat of the division LFSR, lane 0 first since it is the highest degree.
    function automatic logic [PW-1:0] rs_step(input logic [PW-1:0] par,
                                              input logic [SW-1:0] data);
        logic [PW-1:0]      p;
        logic [EGF_DIM-1:0] fb;
        p = par;
        for (int l = 0; l < ENC_SYM; l++) begin
            fb = data[l*EGF_DIM +: EGF_DIM] ^ p[(RSC_PAR_LEN-1)*EGF_DIM +: EGF_DIM];
            for (int j = RSC_PAR_LEN - 1; j > 0; j--)
                p[j*EGF_DIM +: EGF_DIM] = p[(j-1)*EGF_DIM +: EGF_DIM]
                                        ^ gf_mul(fb, GEN[j*EGF_DIM +: EGF_DIM]);
            p[0 +: EGF_DIM] = gf_mul(fb, GEN[0 +: EGF_DIM]);
        end
        return p;
    endfunction

    typedef enum logic [1:0] {IDLE = 2'd0, MSG = 2'd1, PAR = 2'd2} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   msg_q, msg_d, cnt_q, cnt_d, start_beats;
    logic [PCW-1:0]  pcnt_q, pcnt_d;
    logic            byp_q, byp_d, byp_eff, beat_last;
    logic [PW-1:0]   par_q, par_d, par_upd;
    logic            ov_q, ov_d, ol_q, ol_d, op_q, op_d;
    logic [SW-1:0]   od_q, od_d;
    logic            out_free;

    assign out_free        = !ov_q || strm.out_ready;
    assign strm.out_valid  = ov_q;
    assign strm.out_data   = od_q;
    assign strm.out_last   = ol_q;
    assign strm.out_parity = op_q;
    assign dbg_state       = state_q;

    always_comb begin
        state_d = state_q;
        msg_d   = msg_q;
        byp_d   = byp_q;
        cnt_d   = cnt_q;
        pcnt_d  = pcnt_q;
        par_d   = par_q;
        ov_d    = ov_q;
        od_d    = od_q;
        ol_d    = ol_q;
        op_d    = op_q;
        if (cfg_msg_beats == '0)                     start_beats = CW'(1);
        else if (cfg_msg_beats > CW'(MAX_MSG_BEATS)) start_beats = CW'(MAX_MSG_BEATS);
        else                                         start_beats = cfg_msg_beats;
        par_upd   = rs_step(par_q, strm.in_data);
        byp_eff   = (state_q == IDLE) ? cfg_bypass : byp_q;
        beat_last = (state_q == IDLE) ? (start_beats == CW'(1))
                                      : (cnt_q + CW'(1) == msg_q);
        strm.in_ready = (state_q != PAR) && out_free;
        if (out_free) ov_d = 1'b0;

        case (state_q)
            IDLE, MSG: begin
                if (strm.in_valid && out_free) begin
                    ov_d = 1'b1;
                    od_d = strm.in_data;
                    op_d = 1'b0;
                    ol_d = byp_eff && beat_last;
                    if (state_q == IDLE) begin
                        msg_d = start_beats;
                        byp_d = cfg_bypass;
                        cnt_d = CW'(1);
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                    if (!beat_last) begin
                        state_d = MSG;
                        par_d   = par_upd;
                    end else if (byp_eff) begin
                        state_d = IDLE;
                        par_d   = '0;
                        cnt_d   = '0;
                    end else begin
                        state_d = PAR;
                        par_d   = par_upd;
                        pcnt_d  = '0;
                        cnt_d   = '0;
                    end
                end
            end
            PAR: begin
                if (out_free) begin
                    ov_d = 1'b1;
                    op_d = 1'b1;
                    for (int l = 0; l < ENC_SYM; l++)
                        od_d[l*EGF_DIM +: EGF_DIM] = par_q[(RSC_PAR_LEN-1-l)*EGF_DIM +: EGF_DIM];
                    // Shifting up by a beat keeps the next beat's symbols at the top.
                    par_d  = par_q << SW;
                    pcnt_d = pcnt_q + PCW'(1);
                    ol_d   = (pcnt_q == PCW'(PB - 1));
                    if (pcnt_q == PCW'(PB - 1)) begin
                        state_d = IDLE;
                        par_d   = '0;
                        pcnt_d  = '0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            msg_q   <= '0;
            byp_q   <= 1'b0;
            cnt_q   <= '0;
            pcnt_q  <= '0;
            par_q   <= '0;
            ov_q    <= 1'b0;
            od_q    <= '0;
            ol_q    <= 1'b0;
            op_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            msg_q   <= msg_d;
            byp_q   <= byp_d;
            cnt_q   <= cnt_d;
            pcnt_q  <= pcnt_d;
            par_q   <= par_d;
            ov_q    <= ov_d;
            od_q    <= od_d;
            ol_q    <= ol_d;
            op_q    <= op_d;
        end
    end
endmodule
